// File: rtl/des_key_schedule.sv
// Iterative DES round-subkey generator.
// A 64-bit key goes through PC-1 into two 28-bit halves, C and D. The block
// then emits the sixteen 48-bit subkeys, PC-2(C,D), one per valid/ready
// handshake. It holds a single subkey register and a round counter, with no
// precomputed key table.
// Optional build macro DES_DECRYPT_EN adds a 'decrypt' input. When decrypt is
// set on the load, the subkeys come out in reverse order (K16 first).
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        load,
`ifdef DES_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic        load_ready,
    output logic [47:0] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last_round
);

    // FIPS tables, 1-based bit numbers, MSB (bit 1) first
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    // FIPS bit i of the key sits at key[64-i]; CD bit j sits at cd[56-j]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) r[6'(55 - j)] = k[6'(64 - PC1_T[j])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) r[6'(47 - j)] = cd[6'(56 - PC2_T[j])];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one; every other round rotates by two
    function automatic logic shift_two(input logic [4:0] rnd);
        return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction
`endif

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [27:0] c_ld_d, d_ld_d, c_step_d, d_step_d;
    logic [55:0] pc1_cd;
    logic [47:0] subkey_q;
    logic [3:0]  round_q;
    logic        valid_q, last_q, ready_q, hs;
`ifdef DES_DECRYPT_EN
    logic        dir_q;
`endif

    // Halves for a fresh load and for the next round after a handshake
    always_comb begin
        pc1_cd   = pc1(key_in);
        hs       = valid_q && subkey_ready;
        c_ld_d   = rotl(pc1_cd[55:28], 1'b0);
        d_ld_d   = rotl(pc1_cd[27:0], 1'b0);
        c_step_d = rotl(c_q, shift_two(5'(round_q) + 5'd2));
        d_step_d = rotl(d_q, shift_two(5'(round_q) + 5'd2));
`ifdef DES_DECRYPT_EN
        // Decrypt starts from the unrotated halves (K16) and walks backwards
        if (decrypt) begin
            c_ld_d = pc1_cd[55:28];
            d_ld_d = pc1_cd[27:0];
        end
        if (dir_q) begin
            c_step_d = rotr(c_q, shift_two(5'd16 - 5'(round_q)));
            d_step_d = rotr(d_q, shift_two(5'd16 - 5'(round_q)));
        end
`endif
    end

    // Control FSM with registered subkey, counter and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            subkey_q <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef DES_DECRYPT_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q  <= RUN;
                        c_q      <= c_ld_d;
                        d_q      <= d_ld_d;
                        subkey_q <= pc2({c_ld_d, d_ld_d});
                        round_q  <= '0;
                        valid_q  <= 1'b1;
                        last_q   <= (ROUNDS == 1);
                        ready_q  <= 1'b0;
`ifdef DES_DECRYPT_EN
                        dir_q    <= decrypt;
`endif
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (round_q == 4'(ROUNDS - 1)) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            c_q      <= c_step_d;
                            d_q      <= d_step_d;
                            subkey_q <= pc2({c_step_d, d_step_d});
                            round_q  <= round_q + 4'd1;
                            last_q   <= ((round_q + 4'd1) == 4'(ROUNDS - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready   = ready_q;
    assign subkey_out   = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign last_round   = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed testbench for des_key_schedule.
// The classic key 133457799BBCDFF1 is used with its known subkey list.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        load = 1'b0;
    logic        decrypt = 1'b0;
    logic        load_ready;
    logic [47:0] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  round_idx;
    logic        last_round;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [47:0] ENC_K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .load         (load),
`ifdef DES_DECRYPT_EN
        .decrypt      (decrypt),
`endif
        .load_ready   (load_ready),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last_round   (last_round)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic do_load(input logic [63:0] k);
        @(negedge clk);
        key_in = k;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic check_idle(input string name);
        ntests++;
        if (subkey_valid !== 1'b0 || load_ready !== 1'b1 || last_round !== 1'b0) begin
            nfail++;
            $display("FAIL %s: valid=%b load_ready=%b last=%b, required 0/1/0",
                     name, subkey_valid, load_ready, last_round);
        end
    endtask

    task automatic check_key(input string name, input int idx, input logic [47:0] exp);
        ntests++;
        if (subkey_valid !== 1'b1 || subkey_out !== exp || round_idx !== 4'(idx) ||
            last_round !== (idx == 15) || load_ready !== 1'b0) begin
            nfail++;
            $display("FAIL %s[%0d]: valid=%b key=%h idx=%0d last=%b lr=%b, required 1 %h %0d %b 0",
                     name, idx, subkey_valid, subkey_out, round_idx, last_round, load_ready,
                     exp, idx, (idx == 15));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ntests++;
        if (subkey_valid !== 1'b0 || load_ready !== 1'b1 || round_idx !== 4'd0 ||
            last_round !== 1'b0 || subkey_out !== 48'h0) begin
            nfail++;
            $display("FAIL reset: valid=%b lr=%b idx=%0d last=%b key=%h, required 0 1 0 0 0",
                     subkey_valid, load_ready, round_idx, last_round, subkey_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_encrypt_stream;
        subkey_ready = 1'b1;
        do_load(KEY_A);
        for (int i = 0; i < 16; i++) begin
            check_key("enc", i, ENC_K[i]);
            @(negedge clk);
        end
        check_idle("enc_done");
    endtask

    task automatic test_stall;
        subkey_ready = 1'b0;
        do_load(KEY_A);
        for (int i = 0; i < 5; i++) begin
            check_key("stall_hold", 0, ENC_K[0]);
            @(negedge clk);
        end
        subkey_ready = 1'b1;
        @(negedge clk);
        subkey_ready = 1'b0;
        check_key("stall_pulse", 1, ENC_K[1]);
        @(negedge clk);
        check_key("stall_hold2", 1, ENC_K[1]);
        subkey_ready = 1'b1;
        for (int i = 2; i < 16; i++) begin
            @(negedge clk);
            check_key("stall_drain", i, ENC_K[i]);
        end
        @(negedge clk);
        check_idle("stall_done");
    endtask

    task automatic test_zero_keys;
        logic [63:0] keys [2];
        int hs;
        keys[0] = 64'h0000000000000000;
        keys[1] = 64'h0101010101010101;
        for (int n = 0; n < 2; n++) begin
            subkey_ready = 1'b1;
            do_load(keys[n]);
            hs = 0;
            for (int c = 0; c < 40 && subkey_valid === 1'b1; c++) begin
                ntests++;
                if (subkey_out !== 48'h0 || round_idx !== 4'(hs)) begin
                    nfail++;
                    $display("FAIL zero_key%0d: key=%h idx=%0d, required 0 idx %0d",
                             n, subkey_out, round_idx, hs);
                end
                hs++;
                @(negedge clk);
            end
            ntests++;
            if (hs != 16) begin
                nfail++;
                $display("FAIL zero_key%0d_count: handshakes=%0d, required 16", n, hs);
            end
            check_idle("zero_done");
        end
    endtask

    task automatic test_load_ignored_and_abort;
        subkey_ready = 1'b1;
        do_load(KEY_A);
        for (int i = 0; i < 7; i++) @(negedge clk);
        check_key("pre_ignore", 7, ENC_K[7]);
        key_in = 64'hFFEEDDCCBBAA9988;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        check_key("ignored_load", 8, ENC_K[8]);
        @(negedge clk);
        check_key("pre_abort", 9, ENC_K[9]);
        rst_n = 1'b0;
        #1;
        ntests++;
        if (subkey_valid !== 1'b0 || load_ready !== 1'b1 || round_idx !== 4'd0 ||
            subkey_out !== 48'h0) begin
            nfail++;
            $display("FAIL abort: valid=%b lr=%b idx=%0d key=%h, required 0 1 0 0",
                     subkey_valid, load_ready, round_idx, subkey_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("after_abort");
    endtask

    task automatic test_back_to_back;
        subkey_ready = 1'b1;
        do_load(KEY_A);
        for (int i = 0; i < 16; i++) @(negedge clk);
        check_idle("b2b_gap");
        do_load(KEY_A);
        check_key("b2b_first", 0, ENC_K[0]);
        @(negedge clk);
        check_key("b2b_second", 1, ENC_K[1]);
        for (int i = 2; i < 16; i++) @(negedge clk);
        check_key("b2b_last", 15, ENC_K[15]);
        @(negedge clk);
        check_idle("b2b_done");
    endtask

`ifdef DES_DECRYPT_EN
    task automatic test_decrypt;
        subkey_ready = 1'b1;
        decrypt = 1'b1;
        do_load(KEY_A);
        decrypt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("dec", i, ENC_K[15 - i]);
            @(negedge clk);
        end
        check_idle("dec_done");
        do_load(KEY_A);
        check_key("enc_after_dec", 0, ENC_K[0]);
        for (int i = 0; i < 16; i++) @(negedge clk);
        check_idle("enc_after_dec_done");
    endtask
`endif

    initial begin
        test_reset;
        test_encrypt_stream;
        test_stall;
        test_zero_keys;
        test_load_ignored_and_abort;
        test_back_to_back;
`ifdef DES_DECRYPT_EN
        test_decrypt;
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES subkey generator; sits directly upstream of the E-expansion/key-XOR stage that forms the 6-bit S-box addresses.
- Accepts a 64-bit key, applies PC-1, then emits the sixteen 48-bit round subkeys (PC-2 of rotated C/D halves) one per handshake.
- One subkey register and a round counter; no precomputed key table.

Parameters:
- ROUNDS, 16, number of subkeys emitted per load; fixed at 16 for DES, exposed only for bench shortening.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  64  key [64:1]; FIPS bit i maps to key_in[65-i]; parity bits (FIPS 8,16,...,64) ignored.
- load  input  1  start request; accepted only when load_ready=1.
- load_ready  output  1  high in IDLE.
- subkey_out  output  48  current subkey [48:1]; FIPS bit i maps to subkey_out[49-i]; bits 48:43 feed S1 ... bits 6:1 feed S8.
- subkey_valid  output  1  subkey_out holds a valid round key.
- subkey_ready  input  1  consumer accepts subkey_out this cycle.
- round_idx  output  4  0-based index of presented subkey (0 = K1 in encrypt order).
- last_round  output  1  high with subkey_valid when round_idx = ROUNDS-1.

Behaviour:
- Reset (async, rst_n=0): state IDLE, C=D=0, round_idx=0, subkey_valid=0, last_round=0, load_ready=1; subkey_out=0.
- Asserting rst_n low mid-schedule aborts immediately to IDLE; no partial outputs after release.
- FSM states:
  - IDLE: load_ready=1.
  - RUN: subkey_valid=1.
- IDLE to RUN on the load edge:
  - Encrypt: C,D = PC-1 halves rotated left by 1 (shift of round 1).
  - round_idx=0.
  - Latency: subkey_valid rises the cycle after load is sampled.
- load while in RUN is ignored; key_in is sampled only on the accepted load edge.
- In RUN:
  - subkey_out = PC-2(C,D), registered, stable while subkey_valid && !subkey_ready.
  - On a handshake (valid && ready) with round_idx < ROUNDS-1: round_idx++, C and D rotate left by the shift of the next round.
  - Rounds 1,2,9,16 shift by 1; all others shift by 2 (rotation within each 28-bit half).
  - New subkey is presented the next cycle; back-to-back handshakes give 1 subkey/cycle.
- Handshake on round_idx = ROUNDS-1: go to IDLE, subkey_valid=0, last_round=0, load_ready=1 next cycle.
  - load is not accepted in that same cycle; a new load needs load_ready=1.
- Cumulative rotation after K16 is 28, so C,D equal the unrotated PC-1 halves at the end of a schedule (checkable).
- subkey_ready while subkey_valid=0 has no effect.

Optional Feature:
- DES_DECRYPT_EN defined: adds input port decrypt (1 bit), sampled on the accepted load.
  - decrypt=1: C,D load unrotated PC-1 halves, so K16 is presented first.
  - On each handshake the halves rotate right by the shift of the round just presented, giving K16, K15, ..., K1.
  - round_idx still counts 0..15 in emission order; decrypt=0 behaves exactly as encrypt.
- Macro undefined: no decrypt port; encrypt order only; no rotate-right logic.

Test Plan:
- Reset then load key 0x133457799BBCDFF1, subkey_ready=1 held -> cycle+1 subkey 0x1B02EFFC7072 (idx 0); next 0x79AED9DBC9E5 (idx 1); idx 15 = 0xCB3D8B0E17F5 with last_round=1; load_ready=1 the following cycle.
- Same key, subkey_ready=0 for 5 cycles after the first valid -> subkey_out stays 0x1B02EFFC7072, idx 0; one ready pulse -> 0x79AED9DBC9E5.
- Key 0x0000000000000000 and key with only parity bits set (0x0101010101010101) -> all 16 subkeys 0x000000000000.
- Pulse load at idx 7 with a different key -> ignored, sequence continues unchanged; assert rst_n=0 at idx 9 -> immediate IDLE, subkey_valid=0, load_ready=1.
- DES_DECRYPT_EN, decrypt=1, key 0x133457799BBCDFF1 -> first subkey 0xCB3D8B0E17F5, last (idx 15) 0x1B02EFFC7072.
- Random keys vs a software model, random ready gaps, both directions -> every emitted subkey matches; exactly 16 handshakes per load.
